// File: rtl/fmps_readout_scheduler_if.sv
// fmps_readout_scheduler_if: start/bitmap, DPRAM readout, output stream and status bundle.
interface fmps_readout_scheduler_if #(parameter int INDEX_WIDTH = 5);
    localparam int N = 1 << INDEX_WIDTH;
    logic                   start;
    logic [N-1:0]           bitmapA;
    logic [N-1:0]           bitmapB;
    logic [INDEX_WIDTH-1:0] readoutAddress;
    logic [31:0]            readoutFMPS_A;
    logic [31:0]            readoutFMPS_B;
    logic                   outValid;
    logic                   outReady;
    logic [INDEX_WIDTH-1:0] outIndex;
    logic [31:0]            outData;
    logic                   outLast;
    logic                   busy;
    logic                   done;
    logic [INDEX_WIDTH:0]   entryCount;
    logic [15:0]            mismatchCount;
    logic [15:0]            overrunCount;
    modport master (
        output start, bitmapA, bitmapB, readoutFMPS_A, readoutFMPS_B, outReady,
        input  readoutAddress, outValid, outIndex, outData, outLast, busy, done,
               entryCount, mismatchCount, overrunCount
    );
    modport slave (
        input  start, bitmapA, bitmapB, readoutFMPS_A, readoutFMPS_B, outReady,
        output readoutAddress, outValid, outIndex, outData, outLast, busy, done,
               entryCount, mismatchCount, overrunCount
    );
endinterface

// File: rtl/fmps_readout_scheduler.sv
// fmps_readout_scheduler: scans both link FMPS bitmaps per FA cycle and merges present entries into one stream.
module fmps_readout_scheduler #(
    parameter int INDEX_WIDTH = 5
) (
    input logic                     sysClk,
    input logic                     sysReset_n,
    fmps_readout_scheduler_if.slave bus
);
    localparam int N = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;
    typedef enum logic [2:0] {IDLE, SCAN, WAIT1, WAIT2, CAPTURE, OUTPUT, DONE} state_e;
    state_e                 state_q, state_d;
    logic [N-1:0]           map_a_q, map_a_d, map_b_q, map_b_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d, out_index_q, out_index_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [INDEX_WIDTH:0]   entry_q, entry_d;
    logic [15:0]            mism_q, mism_d, overrun_q, overrun_d;
    logic [N-1:0]           m, above;
    always_comb begin
        m           = map_a_q | map_b_q;
        above       = m >> idx_q;
        state_d     = state_q;
        map_a_d     = map_a_q;
        map_b_d     = map_b_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        entry_d     = entry_q;
        mism_d      = mism_q;
        overrun_d   = (bus.start && state_q != IDLE && overrun_q != 16'hFFFF) ? overrun_q + 16'd1 : overrun_q;
        case (state_q)
            IDLE: if (bus.start) begin
                map_a_d = bus.bitmapA;
                map_b_d = bus.bitmapB;
                idx_d   = '0;
                entry_d = '0;
                busy_d  = 1'b1;
                state_d = SCAN;
            end
            SCAN: if (m[idx_q]) begin
                addr_d  = idx_q;
                state_d = WAIT1;
            end else if (idx_q == IDX_MAX) begin
                state_d = DONE;
            end else begin
                idx_d = idx_q + INDEX_WIDTH'(1);
            end
            WAIT1: state_d = WAIT2;
            WAIT2: state_d = CAPTURE;
            CAPTURE: begin
                // Link A wins when both links report the index
                out_data_d  = map_a_q[idx_q] ? bus.readoutFMPS_A : bus.readoutFMPS_B;
                mism_d      = (map_a_q[idx_q] && map_b_q[idx_q] && bus.readoutFMPS_A != bus.readoutFMPS_B
                               && mism_q != 16'hFFFF) ? mism_q + 16'd1 : mism_q;
                out_index_d = idx_q;
                out_last_d  = ~|above[N-1:1];
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: if (out_valid_q && bus.outReady) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                entry_d     = entry_q + (INDEX_WIDTH+1)'(1);
                state_d     = (out_last_q || idx_q == IDX_MAX) ? DONE : SCAN;
                idx_d       = (out_last_q || idx_q == IDX_MAX) ? idx_q : idx_q + INDEX_WIDTH'(1);
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            state_q     <= IDLE;
            map_a_q     <= '0;
            map_b_q     <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            entry_q     <= '0;
            mism_q      <= '0;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            map_a_q     <= map_a_d;
            map_b_q     <= map_b_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            entry_q     <= entry_d;
            mism_q      <= mism_d;
            overrun_q   <= overrun_d;
        end
    end
    assign bus.readoutAddress = addr_q;
    assign bus.outValid       = out_valid_q;
    assign bus.outIndex       = out_index_q;
    assign bus.outData        = out_data_q;
    assign bus.outLast        = out_last_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.entryCount     = entry_q;
    assign bus.mismatchCount  = mism_q;
    assign bus.overrunCount   = overrun_q;
endmodule

// File: tb/tb_fmps_readout_scheduler.sv
// tb_fmps_readout_scheduler: directed scans with a scoreboard of expected output beats.
module tb_fmps_readout_scheduler;
    localparam int IW = 5;
    localparam int N = 1 << IW;
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   data;
        logic          last;
    } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fmps_readout_scheduler_if #(.INDEX_WIDTH(IW)) bus();
    fmps_readout_scheduler #(.INDEX_WIDTH(IW)) dut (.sysClk(clk), .sysReset_n(rst_n), .bus(bus));
    logic [31:0] mem_a [N];
    logic [31:0] mem_b [N];
    always @(posedge clk) begin
        bus.readoutFMPS_A <= mem_a[bus.readoutAddress];
        bus.readoutFMPS_B <= mem_b[bus.readoutAddress];
    end
    int total = 0;
    int bad = 0;
    int exp_mism = 0;
    ent_t q[$];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    logic prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [IW-1:0] prev_idx;
    logic prev_last;
    always @(negedge clk) begin
        ent_t e;
        if (prev_stall) begin
            chk("hold_valid", 64'(bus.outValid), 64'd1);
            chk("hold_data", 64'(bus.outData), 64'(prev_data));
            chk("hold_index", 64'(bus.outIndex), 64'(prev_idx));
            chk("hold_last", 64'(bus.outLast), 64'(prev_last));
        end
        if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
            chk("sb_has_entry", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("beat_index", 64'(bus.outIndex), 64'(e.idx));
                chk("beat_data", 64'(bus.outData), 64'(e.data));
                chk("beat_last", 64'(bus.outLast), 64'(e.last));
            end
        end
        prev_stall = (bus.outValid === 1'b1 && bus.outReady === 1'b0);
        prev_data  = bus.outData;
        prev_idx   = bus.outIndex;
        prev_last  = bus.outLast;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic int exp_cycles(input logic [N-1:0] m);
        int hi = -1;
        int c = 0;
        for (int i = 0; i < N; i++) if (m[i]) hi = i;
        if (hi < 0) return N + 1;
        for (int i = 0; i <= hi; i++) c += m[i] ? 5 : 1;
        return c + 1;
    endfunction
    task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] m;
        int hi;
        ent_t e;
        m = a | b;
        hi = -1;
        for (int i = 0; i < N; i++) if (m[i]) hi = i;
        for (int i = 0; i < N; i++) if (m[i]) begin
            e.idx  = IW'(i);
            e.data = a[i] ? mem_a[i] : mem_b[i];
            e.last = (i == hi);
            q.push_back(e);
            if (a[i] && b[i] && mem_a[i] != mem_b[i]) exp_mism++;
        end
        bus.bitmapA = a;
        bus.bitmapB = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_rise", 64'(bus.busy), 64'd1);
    endtask
    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(bus.done), 64'd1);
        chk("busy_fall", 64'(bus.busy), 64'd0);
    endtask
    task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        do_start(a, b);
        wait_done(400, n);
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles(a | b)));
        chk({tag, "_entries"}, 64'(bus.entryCount), 64'($countones(a | b)));
        chk({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
        chk({tag, "_mismatch"}, 64'(bus.mismatchCount), 64'(exp_mism));
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask
    initial begin
        int n;
        int k;
        bus.start = 1'b0;
        bus.bitmapA = '0;
        bus.bitmapB = '0;
        bus.outReady = 1'b1;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        rst_n = 1'b0;
        bus.start = 1'b1;
        repeat (3) tick();
        chk("rst_addr", 64'(bus.readoutAddress), 64'd0);
        chk("rst_valid", 64'(bus.outValid), 64'd0);
        chk("rst_index", 64'(bus.outIndex), 64'd0);
        chk("rst_data", 64'(bus.outData), 64'd0);
        chk("rst_last", 64'(bus.outLast), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_entries", 64'(bus.entryCount), 64'd0);
        chk("rst_mismatch", 64'(bus.mismatchCount), 64'd0);
        chk("rst_overrun", 64'(bus.overrunCount), 64'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
        mem_a[4] = 32'hDEADBEEF;
        run("single_a", 32'h0000_0010, 32'h0);
        mem_a[7] = 32'h1;
        mem_b[7] = 32'h2;
        run("mismatch", 32'h80, 32'h80);
        chk("mismatch_one", 64'(bus.mismatchCount), 64'd1);
        mem_a[7] = 32'h5;
        mem_b[7] = 32'h5;
        run("match", 32'h80, 32'h80);
        chk("mismatch_still_one", 64'(bus.mismatchCount), 64'd1);
        mem_a[0] = 32'hAAAA_0000;
        mem_a[31] = 32'hBBBB_1111;
        bus.outReady = 1'b0;
        do_start(32'h8000_0001, 32'h0);
        k = 0;
        while (bus.outValid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("bp_valid", 64'(bus.outValid), 64'd1);
        repeat (10) tick();
        chk("bp_index0", 64'(bus.outIndex), 64'd0);
        chk("bp_data0", 64'(bus.outData), 64'hAAAA_0000);
        bus.outReady = 1'b1;
        wait_done(200, n);
        chk("bp_entries", 64'(bus.entryCount), 64'd2);
        chk("bp_sb_empty", 64'(q.size()), 64'd0);
        tick();
        run("empty", 32'h0, 32'h0);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = (i % 3 == 0) ? mem_a[i] : $urandom;
        end
        do_start('1, '1);
        repeat (19) tick();
        bus.bitmapA = 32'h0;
        bus.bitmapB = 32'h0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(400, n);
        chk("ovr_count", 64'(bus.overrunCount), 64'd1);
        chk("ovr_entries", 64'(bus.entryCount), 64'd32);
        chk("ovr_mismatch", 64'(bus.mismatchCount), 64'(exp_mism));
        chk("ovr_sb_empty", 64'(q.size()), 64'd0);
        tick();
        bus.bitmapA = 32'h0;
        bus.bitmapB = 32'h0;
        bus.start = 1'b1;
        k = 0;
        while (bus.overrunCount !== 16'hFFFF && k < 69000) begin
            tick();
            k++;
        end
        chk("ovr_reach_max", 64'(bus.overrunCount), 64'hFFFF);
        repeat (40) tick();
        chk("ovr_saturate", 64'(bus.overrunCount), 64'hFFFF);
        bus.start = 1'b0;
        k = 0;
        while (bus.busy !== 1'b0 && k < 60) begin
            tick();
            k++;
        end
        chk("final_idle", 64'(bus.busy), 64'd0);
        chk("final_sb_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
